// File: rtl/psram_line_fetcher.sv
// Fetches one scan line of 8-bit palette indices from PSRAM into a two-bank line buffer,
// while the display pipeline reads pixels from the other bank.
`timescale 1ns / 1ps

module psram_line_fetcher #(
  parameter int unsigned BASE_ADDR   = 1078,
  parameter int unsigned LINE_WORDS  = 320,
  parameter int unsigned LINE_STRIDE = 320,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_req,
  input  logic [9:0]  line_num,
  input  logic        swap,
  input  logic [9:0]  rd_idx,
  output logic [7:0]  rd_pix,
  output logic        busy,
  output logic        line_done,
  output logic        overrun,
  output logic [22:0] MemAdr,
  output logic        MemOE,
  output logic        RamCE,
  output logic        MemWR,
  output logic        RamLB,
  output logic        RamUB,
  input  logic [15:0] MemDataIn
);

  localparam int unsigned PTR_W = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {StIdle, StAddr, StWait, StCapture, StDone} state_e;

  state_e             r_state;
  logic [PTR_W-1:0]   r_word_ptr;
  logic [3:0]         r_wait_cnt;
  logic               r_disp_bank;
  logic [15:0]        r_buf0 [LINE_WORDS];
  logic [15:0]        r_buf1 [LINE_WORDS];

  logic [22:0]        w_line_base;
  logic               w_rd_ok;
  logic [15:0]        w_rd_word;

  assign MemWR = 1'b1;
  assign RamLB = 1'b0;
  assign RamUB = 1'b0;

  // Address arithmetic wraps modulo 2^23.
  assign w_line_base = 23'(BASE_ADDR) + 23'(line_num) * 23'(LINE_STRIDE);
  assign w_rd_ok     = rd_idx < 10'(2 * LINE_WORDS);

  always_comb begin
    w_rd_word = 16'h0000;
    if (w_rd_ok) begin
      w_rd_word = r_disp_bank ? r_buf1[rd_idx[9:1]] : r_buf0[rd_idx[9:1]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_word_ptr  <= '0;
      r_wait_cnt  <= '0;
      r_disp_bank <= 1'b0;
      MemAdr      <= '0;
      MemOE       <= 1'b1;
      RamCE       <= 1'b1;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (line_req && busy) begin
        overrun <= 1'b1;
      end
      // A swap in the same idle cycle as line_req lands first: the fetch fills ~new display.
      if (swap) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          r_disp_bank <= ~r_disp_bank;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (line_req) begin
            r_word_ptr <= '0;
            MemAdr     <= w_line_base;
            busy       <= 1'b1;
            r_state    <= StAddr;
          end
        end
        StAddr: begin
          RamCE      <= 1'b0;
          MemOE      <= 1'b0;
          r_wait_cnt <= 4'(WAIT_CYCLES);
          r_state    <= StWait;
        end
        StWait: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt <= 4'd1) begin
            r_state <= StCapture;
          end
        end
        StCapture: begin
          RamCE <= 1'b1;
          MemOE <= 1'b1;
          if (r_word_ptr == PTR_W'(LINE_WORDS - 1)) begin
            r_state <= StDone;
          end else begin
            r_word_ptr <= r_word_ptr + 1'b1;
            MemAdr     <= MemAdr + 23'd1;
            r_state    <= StAddr;
          end
        end
        StDone: begin
          line_done <= 1'b1;
          busy      <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Line buffer is not reset; the fill bank is always the one not on display.
  always_ff @(posedge clk) begin
    if (r_state == StCapture) begin
      if (r_disp_bank) begin
        r_buf0[r_word_ptr] <= MemDataIn;
      end else begin
        r_buf1[r_word_ptr] <= MemDataIn;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pix <= 8'h00;
    end else begin
      rd_pix <= rd_idx[0] ? w_rd_word[15:8] : w_rd_word[7:0];
    end
  end

endmodule

// File: tb/tb_psram_line_fetcher.sv
// Directed bench for psram_line_fetcher: default timing instance plus a WAIT_CYCLES=1 instance,
// each fed by a PSRAM model that returns the low 16 bits of the address.
`timescale 1ns / 1ps

module tb_psram_line_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        line_req1 = 1'b0, swap1 = 1'b0;
  logic [9:0]  line_num1 = '0, rd_idx1 = '0;
  logic [7:0]  rd_pix1;
  logic        busy1, line_done1, overrun1, MemOE1, RamCE1, MemWR1, RamLB1, RamUB1;
  logic [22:0] MemAdr1;
  logic [15:0] MemDataIn1;

  logic        line_req2 = 1'b0, swap2 = 1'b0;
  logic [9:0]  line_num2 = '0, rd_idx2 = '0;
  logic [7:0]  rd_pix2;
  logic        busy2, line_done2, overrun2, MemOE2, RamCE2, MemWR2, RamLB2, RamUB2;
  logic [22:0] MemAdr2;
  logic [15:0] MemDataIn2;

  int n_checks = 0;
  int n_fail   = 0;

  assign MemDataIn1 = MemAdr1[15:0];
  assign MemDataIn2 = MemAdr2[15:0];

  always #5 clk = ~clk;

  psram_line_fetcher dut1 (
    .clk(clk), .reset(reset), .line_req(line_req1), .line_num(line_num1), .swap(swap1),
    .rd_idx(rd_idx1), .rd_pix(rd_pix1), .busy(busy1), .line_done(line_done1),
    .overrun(overrun1), .MemAdr(MemAdr1), .MemOE(MemOE1), .RamCE(RamCE1), .MemWR(MemWR1),
    .RamLB(RamLB1), .RamUB(RamUB1), .MemDataIn(MemDataIn1)
  );

  psram_line_fetcher #(.WAIT_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .line_req(line_req2), .line_num(line_num2), .swap(swap2),
    .rd_idx(rd_idx2), .rd_pix(rd_pix2), .busy(busy2), .line_done(line_done2),
    .overrun(overrun2), .MemAdr(MemAdr2), .MemOE(MemOE2), .RamCE(RamCE2), .MemWR(MemWR2),
    .RamLB(RamLB2), .RamUB(RamUB2), .MemDataIn(MemDataIn2)
  );

  // Requests a line on dut1 (optionally with a simultaneous swap) and runs it to line_done.
  task automatic run1(input logic [9:0] ln, input logic with_swap, input int req_at,
                      input int swap_at, output int cyc, output logic [22:0] first,
                      output logic [22:0] last, output logic [22:0] maxa,
                      output logic busy_start);
    @(negedge clk);
    line_num1 = ln;
    line_req1 = 1'b1;
    swap1     = with_swap;
    @(negedge clk);
    line_req1  = 1'b0;
    swap1      = 1'b0;
    cyc        = 0;
    first      = MemAdr1;
    busy_start = busy1;
    last       = '0;
    maxa       = '0;
    while (!line_done1 && cyc < 3000) begin
      if (!MemOE1) begin
        last = MemAdr1;
        if (MemAdr1 > maxa) maxa = MemAdr1;
      end
      @(negedge clk);
      cyc++;
      line_req1 = (cyc == req_at);
      if (line_req1) line_num1 = 10'd5;
      swap1 = (cyc == swap_at);
    end
    line_req1 = 1'b0;
    swap1     = 1'b0;
  endtask

  task automatic rd1(input logic [9:0] idx, output logic [7:0] pix);
    @(negedge clk);
    rd_idx1 = idx;
    @(negedge clk);
    pix = rd_pix1;
  endtask

  task automatic pulse_swap1();
    @(negedge clk);
    swap1 = 1'b1;
    @(negedge clk);
    swap1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({MemOE1, RamCE1, MemWR1, RamLB1, RamUB1, busy1, line_done1, overrun1} !== 8'b11100000)
    begin
      n_fail++;
      $display("FAIL reset_ctrl1: got %b expected 11100000",
               {MemOE1, RamCE1, MemWR1, RamLB1, RamUB1, busy1, line_done1, overrun1});
    end
    n_checks++;
    if ({MemOE2, RamCE2, MemWR2, RamLB2, RamUB2, busy2, line_done2, overrun2} !== 8'b11100000)
    begin
      n_fail++;
      $display("FAIL reset_ctrl2: got %b expected 11100000",
               {MemOE2, RamCE2, MemWR2, RamLB2, RamUB2, busy2, line_done2, overrun2});
    end
    n_checks++;
    if (rd_pix1 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd_pix: got %h expected 00", rd_pix1);
    end
    n_checks++;
    if (MemAdr1 !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_adr: got %0d expected 0", MemAdr1);
    end
  endtask

  task automatic test_fetch();
    int cyc;
    logic [22:0] first, last, maxa;
    logic bs;
    run1(10'd2, 1'b0, -1, -1, cyc, first, last, maxa, bs);
    n_checks++;
    if (first !== 23'd1718) begin
      n_fail++;
      $display("FAIL fetch_first_adr: got %0d expected 1718", first);
    end
    n_checks++;
    if (last !== 23'd2037) begin
      n_fail++;
      $display("FAIL fetch_last_adr: got %0d expected 2037", last);
    end
    n_checks++;
    if (cyc != 1601) begin
      n_fail++;
      $display("FAIL fetch_done_cycle: got %0d expected 1601", cyc);
    end
    n_checks++;
    if (bs !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_busy_rise: got %b expected 1", bs);
    end
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_busy_fall: got %b expected 0", busy1);
    end
  endtask

  task automatic test_swap_same_cycle();
    int cyc;
    logic [22:0] first, last, maxa;
    logic bs;
    logic [7:0] pix;
    run1(10'd3, 1'b1, -1, -1, cyc, first, last, maxa, bs);
    n_checks++;
    if (first !== 23'd2038 || cyc != 1601) begin
      n_fail++;
      $display("FAIL same_fetch: got adr %0d cyc %0d expected adr 2038 cyc 1601", first, cyc);
    end
    rd1(10'd0, pix);
    n_checks++;
    if (pix !== 8'hB6) begin
      n_fail++;
      $display("FAIL same_pix0: got %h expected b6", pix);
    end
    rd1(10'd1, pix);
    n_checks++;
    if (pix !== 8'h06) begin
      n_fail++;
      $display("FAIL same_pix1: got %h expected 06", pix);
    end
    rd1(10'd639, pix);
    n_checks++;
    if (pix !== 8'h07) begin
      n_fail++;
      $display("FAIL same_pix639: got %h expected 07", pix);
    end
    rd1(10'd700, pix);
    n_checks++;
    if (pix !== 8'h00) begin
      n_fail++;
      $display("FAIL same_pix700: got %h expected 00", pix);
    end
    pulse_swap1();
    rd1(10'd0, pix);
    n_checks++;
    if (pix !== 8'hF6) begin
      n_fail++;
      $display("FAIL same_new_pix0: got %h expected f6", pix);
    end
    rd1(10'd1, pix);
    n_checks++;
    if (pix !== 8'h07) begin
      n_fail++;
      $display("FAIL same_new_pix1: got %h expected 07", pix);
    end
    n_checks++;
    if (overrun1 !== 1'b0) begin
      n_fail++;
      $display("FAIL same_no_overrun: got %b expected 0", overrun1);
    end
  endtask

  task automatic test_overrun();
    int cyc;
    logic [22:0] first, last, maxa;
    logic bs;
    logic [7:0] pix;
    run1(10'd0, 1'b0, 100, 200, cyc, first, last, maxa, bs);
    n_checks++;
    if (cyc != 1601 || first !== 23'd1078) begin
      n_fail++;
      $display("FAIL ovr_fetch: got cyc %0d adr %0d expected cyc 1601 adr 1078", cyc, first);
    end
    n_checks++;
    if (last !== 23'd1397 || maxa !== 23'd1397) begin
      n_fail++;
      $display("FAIL ovr_last_adr: got last %0d max %0d expected 1397", last, maxa);
    end
    n_checks++;
    if (overrun1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b expected 1", overrun1);
    end
    rd1(10'd0, pix);
    n_checks++;
    if (pix !== 8'hF6) begin
      n_fail++;
      $display("FAIL ovr_bank_kept: got %h expected f6", pix);
    end
    pulse_swap1();
    rd1(10'd0, pix);
    n_checks++;
    if (pix !== 8'h36) begin
      n_fail++;
      $display("FAIL ovr_new_pix0: got %h expected 36", pix);
    end
    rd1(10'd1, pix);
    n_checks++;
    if (pix !== 8'h04) begin
      n_fail++;
      $display("FAIL ovr_new_pix1: got %h expected 04", pix);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (overrun1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun1);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [22:0] first, last, maxa;
    logic bs;
    @(negedge clk);
    line_num1 = 10'd1;
    line_req1 = 1'b1;
    @(negedge clk);
    line_req1 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({MemOE1, RamCE1} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_strobes_low: got %b expected 00", {MemOE1, RamCE1});
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({MemOE1, RamCE1, busy1} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_async: got %b expected 110", {MemOE1, RamCE1, busy1});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy1, overrun1} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_after_release: got %b expected 00", {busy1, overrun1});
    end
    run1(10'd1, 1'b0, -1, -1, cyc, first, last, maxa, bs);
    n_checks++;
    if (first !== 23'd1398 || last !== 23'd1717) begin
      n_fail++;
      $display("FAIL mid_restart_adr: got %0d..%0d expected 1398..1717", first, last);
    end
    n_checks++;
    if (cyc != 1601) begin
      n_fail++;
      $display("FAIL mid_restart_cycle: got %0d expected 1601", cyc);
    end
  endtask

  task automatic test_wait1();
    int cyc = 0;
    int oe_low = 0;
    int falls = 0;
    logic prev_oe;
    logic [22:0] first;
    @(negedge clk);
    line_num2 = 10'd2;
    line_req2 = 1'b1;
    @(negedge clk);
    line_req2 = 1'b0;
    first   = MemAdr2;
    prev_oe = MemOE2;
    while (!line_done2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!MemOE2) oe_low++;
      if (prev_oe && !MemOE2) falls++;
      prev_oe = MemOE2;
    end
    n_checks++;
    if (cyc != 961) begin
      n_fail++;
      $display("FAIL w1_done_cycle: got %0d expected 961", cyc);
    end
    n_checks++;
    if (oe_low != 640) begin
      n_fail++;
      $display("FAIL w1_oe_low_total: got %0d expected 640", oe_low);
    end
    n_checks++;
    if (falls != 320) begin
      n_fail++;
      $display("FAIL w1_oe_pulses: got %0d expected 320", falls);
    end
    n_checks++;
    if (first !== 23'd1718) begin
      n_fail++;
      $display("FAIL w1_first_adr: got %0d expected 1718", first);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_swap_same_cycle();
    test_overrun();
    test_reset_mid();
    test_wait1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_line_fetcher.md
# psram_line_fetcher

Fetches one 640-pixel scan line of 8-bit palette indices from the PSRAM, one 16-bit word at a time, into a two-bank line buffer. The display pipeline reads the other bank pixel-by-pixel. The block sits between the PSRAM pins and the palette/VGA output stage. The sync/timing logic asks for the next line with `line_req` and flips banks with `swap` at end of line.

## Interface
- `BASE_ADDR`, 1078: PSRAM word address of pixel 0 of line 0.
- `LINE_WORDS`, 320: words fetched per line (2 pixels per word).
- `LINE_STRIDE`, 320: word-address distance between consecutive lines.
- `WAIT_CYCLES`, 3: cycles from OE/CE low to data sample; legal range 1..15.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `line_req` in 1: one-cycle pulse requesting a fetch of `line_num`.
- `line_num` in 10: line to fetch; sampled only when `line_req` is accepted.
- `swap` in 1: one-cycle pulse exchanging the display and fill banks.
- `rd_idx` in 10: pixel index (0..639) read from the display bank.
- `rd_pix` out 8: palette index at `rd_idx`; registered.
- `busy` out 1: high while a fetch is in progress.
- `line_done` out 1: one-cycle pulse when the last word of a line is written.
- `overrun` out 1: sticky error flag; cleared only by reset.
- `MemAdr` out 23: PSRAM word address.
- `MemOE`, `RamCE` out 1 each: active-low read strobes.
- `MemWR` out 1: constant 1 (the block never writes).
- `RamLB`, `RamUB` out 1 each: constant 0 (both bytes enabled).
- `MemDataIn` in 16: PSRAM read data.

## Operation
- Reset values: `MemOE`=1, `RamCE`=1, `MemWR`=1, `RamLB`=0, `RamUB`=0, `MemAdr`=0, `busy`=0, `line_done`=0, `overrun`=0, `rd_pix`=0, display bank = 0, fill bank = 1, state = IDLE.
- Line-buffer RAM contents are not reset.
- FSM states: IDLE, ADDR, WAIT, CAPTURE, DONE.
- IDLE:
  - On `line_req`, latch `line_num` and clear `word_ptr`.
  - Drive `MemAdr` = `BASE_ADDR` + `line_num`*`LINE_STRIDE` + `word_ptr`, computed at 23 bits and wrapping modulo 2^23.
  - Set `busy`=1 and go to ADDR.
- ADDR: drive `RamCE`=0 and `MemOE`=0, load the wait counter with `WAIT_CYCLES`, go to WAIT.
- WAIT: decrement the counter; go to CAPTURE when it reaches 1.
- CAPTURE:
  - Sample `MemDataIn`.
  - Write `[7:0]` to fill-bank pixel 2*`word_ptr` and `[15:8]` to pixel 2*`word_ptr`+1.
  - Drive `RamCE`=1 and `MemOE`=1.
  - If `word_ptr`=`LINE_WORDS`-1, go to DONE. Otherwise increment `word_ptr`, update `MemAdr`, and go to ADDR.
- DONE: pulse `line_done`, set `busy`=0, go to IDLE.
- `line_req` while `busy`=1: ignored, and `overrun` is set.
- `swap` while `busy`=0: toggles both bank selects.
- `swap` while `busy`=1: ignored, and `overrun` is set. The fill bank never changes mid-fetch.
- `swap` and `line_req` in the same IDLE cycle: the swap applies first, so the new fetch fills the bank just released from display.
- Display read: `rd_pix` <= display_bank[`rd_idx`] on every clock. `rd_idx` > 639 yields 0.
- Reset mid-fetch: the FSM returns to IDLE and the strobes go high immediately (asynchronously). The partial line is left in the buffer.

## Timing
- Each word costs `WAIT_CYCLES`+2 cycles: ADDR, then the WAIT cycles, then CAPTURE.
- A full line takes `LINE_WORDS`*(`WAIT_CYCLES`+2)+1 cycles from `line_req` to `line_done`. With defaults this is 1601 cycles.
- `MemAdr` is stable from the ADDR cycle through CAPTURE.
- `RamCE`/`MemOE` are high for at least one cycle between consecutive words.
- `busy` rises the cycle after `line_req` and falls with the `line_done` pulse.
- A new `line_req` is accepted the cycle after `line_done`.
- `rd_pix` latency is 1 cycle from `rd_idx`.

## Test plan
- Reset, then idle 10 cycles -> `MemOE`=`RamCE`=`MemWR`=1, `RamLB`=`RamUB`=0, `busy`=0, `rd_pix`=0.
- PSRAM model returning data = address[15:0]; `line_req` with `line_num`=2 -> first `MemAdr`=1718, last `MemAdr`=2037, `line_done` at cycle 1601. After `swap`, `rd_idx`=0 gives 8'hB6 and `rd_idx`=1 gives 8'h06.
- `WAIT_CYCLES`=1 -> 3 cycles per word, `line_done` at cycle 961, OE low exactly 2 cycles per word.
- `line_req` at cycle 100 of a fetch, plus `swap` at cycle 200 -> fetch unaffected, banks unchanged, `overrun`=1 until reset.
- `swap` and `line_req` in the same IDLE cycle -> old fill bank displayed, fetch writes the old display bank; `rd_idx`=700 -> `rd_pix`=0.
- Assert `reset` midway through a WAIT -> strobes go high without waiting for a clock edge. After release, `busy`=0, and a fresh `line_req` restarts at `word_ptr`=0.
